gin_feed_ctrl: RTL and testbench
================================

# gin_feed_ctrl

Sequencer that drives the global input network FIFO pair. It fetches words from the global buffer through a 1-cycle-latency read port. On request it first loads the GIN row/column ID scan chain from a configuration region. It then streams a data region into the data FIFO and writes a matching generated {col_tag,row_tag} entry into the tags FIFO for every word. It sits between the global-buffer controller and the GIN FIFO wrapper, and is the only writer of both FIFOs.

## Interface
Parameters:
- DATA_WIDTH, 64, buffer word and data FIFO width
- ROW_TAG_WIDTH, 4, row tag width
- COL_TAG_WIDTH, 4, column tag width
- ADDR_WIDTH, 16, buffer address and word-count width
- SCAN_LEN, 720, ID chain length in bits (12·4 + 12·14·4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- start  in  1  launch pass; sampled only in IDLE
- cfg_en  in  1  run SCAN phase before STREAM; sampled with start
- cfg_base  in  ADDR_WIDTH  first address of scan words
- data_base  in  ADDR_WIDTH  first address of data words
- num_words  in  ADDR_WIDTH  words to stream
- row_max  in  ROW_TAG_WIDTH  last row tag
- col_max  in  COL_TAG_WIDTH  last column tag
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at pass end
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  ADDR_WIDTH  buffer read address
- buf_rd_data  in  DATA_WIDTH  valid the cycle after buf_rd_en
- se_id  out  1  ID scan enable
- si_id  out  1  ID scan serial bit
- data_out  out  DATA_WIDTH  data FIFO write data
- data_wr_en  out  1  data FIFO push
- data_full  in  1  data FIFO full
- row_tag  out  ROW_TAG_WIDTH  tag FIFO row field
- col_tag  out  COL_TAG_WIDTH  tag FIFO column field
- tags_wr_en  out  1  tags FIFO push
- tags_full  in  1  tags FIFO full

## Operation
- States: IDLE, SCAN, STREAM, DONE.
- Transitions out of IDLE:
  - start=1 and cfg_en=1 goes to SCAN.
  - start=1, cfg_en=0, num_words≠0 goes to STREAM.
  - start=1, cfg_en=0, num_words=0 goes to DONE.
- Configuration inputs are latched at start. Later changes are ignored until the next pass.
- SCAN:
  - Reads ceil(SCAN_LEN/DATA_WIDTH) words from cfg_base upward.
  - Shifts each word out LSB first on si_id with se_id=1, one bit per cycle.
  - The last word is truncated so exactly SCAN_LEN bits are shifted.
  - After the last bit, go to STREAM, or to DONE if num_words=0.
- STREAM:
  - Reads num_words words from data_base upward.
  - Each returned word is pushed with data_wr_en=tags_wr_en=1 in the same cycle, with the current tags.
  - Tag counters start at row 0, col 0. col increments per push. At col_max, col goes to 0 and row increments. At row_max, row wraps to 0.
  - After the num_words-th push, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- Backpressure:
  - A push happens only when data_full=0 and tags_full=0.
  - A one-entry hold register captures a returned word that cannot be pushed.
  - A read is issued only if the hold register is empty and no returned word is stalled in the current cycle.
  - No word is ever dropped or duplicated.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: all outputs 0; state IDLE; counters and hold register cleared.
- Reset asserted mid-pass aborts immediately. No done pulse is issued and no further FIFO push occurs.
- Read latency is 1 cycle. buf_rd_en at t gives buf_rd_data at t+1.
- STREAM with FIFOs never full:
  - First read the cycle after the STREAM entry.
  - First push one cycle later.
  - One push per cycle afterwards.
  - done is asserted the cycle after the last push.
- SCAN:
  - The first bit appears on si_id the cycle after the first read.
  - The next word's read is issued during the last shift cycle of the current word, so se_id stays high continuously for SCAN_LEN cycles.
- Full flags rising in the same cycle as a returned word: the word goes to the hold register. It is pushed in the first cycle both flags are low, and it is pushed before any newer word.

## Structure
- Package gin_pkg holds the state enum (IDLE/SCAN/STREAM/DONE), the default tag widths, and the SCAN_LEN constant derived from NUM_OF_ROWS, NUM_OF_COLS and the tag widths.
- One natural sub-module: gin_tag_gen, the row/column wrap counter with clear and advance inputs.

## Test plan
- cfg_en=0, num_words=5, row_max=1, col_max=1, FIFOs never full -> pushes on 5 consecutive cycles with (row,col) = (0,0),(0,1),(1,0),(1,1),(0,0); buf_rd_addr runs data_base..data_base+4; one done pulse.
- cfg_en=1, SCAN_LEN=720, DATA_WIDTH=64 -> 12 reads; se_id high for exactly 720 consecutive cycles; si_id bit sequence equals the buffer contents LSB first; STREAM starts afterwards.
- Toggle data_full for 3 cycles during a burst of 8 words -> exactly 8 pushes, in address order, with no push while data_full=1.
- num_words=0, cfg_en=0 -> no reads, done one cycle after start.
- Assert reset during STREAM after 3 pushes -> all outputs 0 next cycle; no done; a new pass after reset runs normally from tag (0,0).
- Pulse start while busy -> ignored; the pass completes with its original configuration.

Source files
------------

// File: rtl/gin_pkg.sv
// Shared definitions for the global input network feed logic.
//   gin_state_t        : sequencer states (IDLE, SCAN, STREAM, DONE)
//   NUM_OF_ROWS/COLS   : PE array geometry the ID scan chain covers
//   GIN_*_TAG_WIDTH    : default row/column tag widths
//   GIN_SCAN_LEN       : ID chain length in bits (one row ID per row,
//                        one column ID per PE)
//   ceil_div()         : integer ceiling division for elaboration-time sizing
package gin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } gin_state_t;

    localparam int unsigned NUM_OF_ROWS       = 12;
    localparam int unsigned NUM_OF_COLS       = 14;
    localparam int unsigned GIN_ROW_TAG_WIDTH = 4;
    localparam int unsigned GIN_COL_TAG_WIDTH = 4;

    localparam int unsigned GIN_SCAN_LEN =
        NUM_OF_ROWS * GIN_ROW_TAG_WIDTH +
        NUM_OF_ROWS * NUM_OF_COLS * GIN_COL_TAG_WIDTH;

    function automatic int unsigned ceil_div(input int unsigned num,
                                             input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/gin_tag_gen.sv
// Row/column tag generator for the GIN tags FIFO.
// Column counts up on every advance; when it passes col_max it returns to 0
// and the row steps, the row in turn wrapping to 0 after row_max.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to (row 0, col 0)
//   advance    : step to the next tag (one per FIFO push)
//   row_max    : last row tag
//   col_max    : last column tag
//   row_tag    : current row tag
//   col_tag    : current column tag
module gin_tag_gen
    import gin_pkg::*;
#(
    parameter int unsigned ROW_TAG_WIDTH = GIN_ROW_TAG_WIDTH,
    parameter int unsigned COL_TAG_WIDTH = GIN_COL_TAG_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    input  logic [ROW_TAG_WIDTH-1:0] row_max,
    input  logic [COL_TAG_WIDTH-1:0] col_max,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_tag <= '0;
            col_tag <= '0;
        end else if (clear) begin
            row_tag <= '0;
            col_tag <= '0;
        end else if (advance) begin
            if (col_tag == col_max) begin
                col_tag <= '0;
                if (row_tag == row_max) begin
                    row_tag <= '0;
                end else begin
                    row_tag <= row_tag + ROW_TAG_WIDTH'(1);
                end
            end else begin
                col_tag <= col_tag + COL_TAG_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/gin_feed_ctrl.sv
// Sequencer feeding the GIN data/tags FIFO pair from the global buffer.
// A pass optionally shifts the ID scan chain from a configuration region
// (SCAN), then streams a data region into the data FIFO with a generated
// {col_tag,row_tag} entry pushed alongside every word (STREAM).
//   clk, reset        : clock, asynchronous active-high reset
//   start, cfg_en     : launch a pass (IDLE only), include SCAN phase
//   cfg_base          : first scan-word address
//   data_base         : first data-word address
//   num_words         : words to stream
//   row_max, col_max  : last row / column tag
//   busy, done        : pass in progress, one-cycle end-of-pass pulse
//   buf_rd_en/addr    : global buffer read port (1-cycle latency)
//   buf_rd_data       : read data, valid the cycle after buf_rd_en
//   se_id, si_id      : ID scan chain enable / serial data
//   data_out/wr_en    : data FIFO push, data_full its full flag
//   row_tag, col_tag  : tags FIFO entry, tags_wr_en push, tags_full flag
module gin_feed_ctrl
    import gin_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ROW_TAG_WIDTH = GIN_ROW_TAG_WIDTH,
    parameter int unsigned COL_TAG_WIDTH = GIN_COL_TAG_WIDTH,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned SCAN_LEN      = GIN_SCAN_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cfg_en,
    input  logic [ADDR_WIDTH-1:0]    cfg_base,
    input  logic [ADDR_WIDTH-1:0]    data_base,
    input  logic [ADDR_WIDTH-1:0]    num_words,
    input  logic [ROW_TAG_WIDTH-1:0] row_max,
    input  logic [COL_TAG_WIDTH-1:0] col_max,
    output logic                     busy,
    output logic                     done,
    output logic                     buf_rd_en,
    output logic [ADDR_WIDTH-1:0]    buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]    buf_rd_data,
    output logic                     se_id,
    output logic                     si_id,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_wr_en,
    input  logic                     data_full,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     tags_wr_en,
    input  logic                     tags_full
);

    localparam int unsigned SCAN_WORDS = ceil_div(SCAN_LEN, DATA_WIDTH);
    localparam int unsigned WCW        = $clog2(SCAN_WORDS + 1);
    localparam int unsigned TBW        = $clog2(SCAN_LEN + 1);
    localparam int unsigned SBW        = $clog2(DATA_WIDTH + 1);

    gin_state_t               state;

    // Pass configuration captured at start
    logic [ADDR_WIDTH-1:0]    data_base_q;
    logic [ADDR_WIDTH-1:0]    num_words_q;
    logic [ROW_TAG_WIDTH-1:0] row_max_q;
    logic [COL_TAG_WIDTH-1:0] col_max_q;

    // Read / push bookkeeping
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [ADDR_WIDTH-1:0]    reads_left;
    logic [ADDR_WIDTH-1:0]    pushes_left;
    logic                     rd_valid;
    logic                     hold_valid;
    logic [DATA_WIDTH-1:0]    hold_data;

    // Scan shifter
    logic [DATA_WIDTH-1:0]    sh_reg;
    logic [SBW-1:0]           sh_left;
    logic [TBW-1:0]           bits_left;
    logic [WCW-1:0]           words_left;

    // Tag generator interface
    logic                     tag_clear;
    logic [ROW_TAG_WIDTH-1:0] gen_row;
    logic [COL_TAG_WIDTH-1:0] gen_col;

    logic                     in_scan;
    logic                     in_stream;
    logic                     fifo_ready;
    logic                     push;
    logic                     stall_ret;
    logic [DATA_WIDTH-1:0]    push_word;
    logic                     scan_shift;
    logic                     scan_bit;
    logic                     word_last_bit;
    logic                     scan_rd;
    logic                     strm_rd;
    logic                     rd_en;

    always_comb begin
        in_scan    = (state == SCAN);
        in_stream  = (state == STREAM);
        fifo_ready = !data_full && !tags_full;

        // The held word is always older than anything in flight, and while
        // it is occupied no read is issued, so at most one of the two is live.
        push       = in_stream && (hold_valid || rd_valid) && fifo_ready;
        push_word  = hold_valid ? hold_data : buf_rd_data;
        stall_ret  = in_stream && rd_valid && !fifo_ready;

        // A freshly returned word shifts its bit 0 in the arrival cycle; the
        // rest comes from sh_reg, giving a gap-free bit stream across words.
        scan_shift    = in_scan && (rd_valid || (sh_left != '0));
        scan_bit      = rd_valid ? buf_rd_data[0] : sh_reg[0];
        word_last_bit = (rd_valid && (DATA_WIDTH == 1)) ||
                        (!rd_valid && (sh_left == SBW'(1)));

        // First scan read goes out on SCAN entry; each later one is issued
        // in the final shift cycle of the current word.
        scan_rd = in_scan && (words_left != '0) && (!scan_shift || word_last_bit);
        strm_rd = in_stream && (reads_left != '0) && !hold_valid && !stall_ret;
        rd_en   = scan_rd || strm_rd;

        tag_clear = (state == IDLE) && start;
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign buf_rd_en   = rd_en;
    assign buf_rd_addr = rd_en ? rd_addr : '0;
    assign se_id       = scan_shift;
    assign si_id       = scan_shift && scan_bit;
    assign data_wr_en  = push;
    assign tags_wr_en  = push;
    assign data_out    = push ? push_word : '0;
    assign row_tag     = push ? gen_row : '0;
    assign col_tag     = push ? gen_col : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_base_q <= '0;
            num_words_q <= '0;
            row_max_q   <= '0;
            col_max_q   <= '0;
            rd_addr     <= '0;
            reads_left  <= '0;
            pushes_left <= '0;
            rd_valid    <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            sh_reg      <= '0;
            sh_left     <= '0;
            bits_left   <= '0;
            words_left  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        data_base_q <= data_base;
                        num_words_q <= num_words;
                        row_max_q   <= row_max;
                        col_max_q   <= col_max;
                        reads_left  <= num_words;
                        pushes_left <= num_words;
                        words_left  <= WCW'(SCAN_WORDS);
                        bits_left   <= TBW'(SCAN_LEN);
                        sh_left     <= '0;
                        hold_valid  <= 1'b0;
                        rd_addr     <= cfg_en ? cfg_base : data_base;
                        if (cfg_en) begin
                            state <= SCAN;
                        end else if (num_words != '0) begin
                            state <= STREAM;
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                SCAN: begin
                    if (scan_rd) begin
                        words_left <= words_left - WCW'(1);
                    end
                    if (scan_shift) begin
                        bits_left <= bits_left - TBW'(1);
                        if (rd_valid) begin
                            sh_reg  <= buf_rd_data >> 1;
                            sh_left <= SBW'(DATA_WIDTH - 1);
                        end else begin
                            sh_reg  <= sh_reg >> 1;
                            sh_left <= sh_left - SBW'(1);
                        end
                        // The final word may be cut short; discarding its
                        // unshifted tail here is what truncates it.
                        if (bits_left == TBW'(1)) begin
                            sh_left <= '0;
                            rd_addr <= data_base_q;
                            state   <= (num_words_q != '0) ? STREAM : DONE;
                        end
                    end
                end

                STREAM: begin
                    if (strm_rd) begin
                        reads_left <= reads_left - ADDR_WIDTH'(1);
                    end
                    if (stall_ret) begin
                        hold_valid <= 1'b1;
                        hold_data  <= buf_rd_data;
                    end else if (push && hold_valid) begin
                        hold_valid <= 1'b0;
                    end
                    if (push) begin
                        pushes_left <= pushes_left - ADDR_WIDTH'(1);
                        if (pushes_left == ADDR_WIDTH'(1)) begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    gin_tag_gen #(
        .ROW_TAG_WIDTH(ROW_TAG_WIDTH),
        .COL_TAG_WIDTH(COL_TAG_WIDTH)
    ) u_tag_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (tag_clear),
        .advance (push),
        .row_max (row_max_q),
        .col_max (col_max_q),
        .row_tag (gen_row),
        .col_tag (gen_col)
    );

endmodule

// File: tb/tb_gin_feed_ctrl.sv
// Self-checking bench for gin_feed_ctrl: a buffer responder, a push/scan
// monitor and a reference model built from the pass configuration.
module tb_gin_feed_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned SL = 720;
    localparam int unsigned SW = (SL + DW - 1) / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cfg_en;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] data_base;
    logic [AW-1:0] num_words;
    logic [RW-1:0] row_max;
    logic [CW-1:0] col_max;
    logic          busy;
    logic          done;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          se_id;
    logic          si_id;
    logic [DW-1:0] data_out;
    logic          data_wr_en;
    logic          data_full;
    logic [RW-1:0] row_tag;
    logic [CW-1:0] col_tag;
    logic          tags_wr_en;
    logic          tags_full;

    gin_feed_ctrl #(
        .DATA_WIDTH    (DW),
        .ROW_TAG_WIDTH (RW),
        .COL_TAG_WIDTH (CW),
        .ADDR_WIDTH    (AW),
        .SCAN_LEN      (SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_en      (cfg_en),
        .cfg_base    (cfg_base),
        .data_base   (data_base),
        .num_words   (num_words),
        .row_max     (row_max),
        .col_max     (col_max),
        .busy        (busy),
        .done        (done),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .se_id       (se_id),
        .si_id       (si_id),
        .data_out    (data_out),
        .data_wr_en  (data_wr_en),
        .data_full   (data_full),
        .row_tag     (row_tag),
        .col_tag     (col_tag),
        .tags_wr_en  (tags_wr_en),
        .tags_full   (tags_full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Unique content per address so ordering/duplication errors are visible
    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return {a, a ^ 16'h5a5a, a * 16'd7 + 16'd3, ~a};
    endfunction

    // Buffer: 1-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem_word(buf_rd_addr);
        else           buf_rd_data <= {$urandom, $urandom};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference expectations for the current pass
    logic [63:0] exp_data[$];
    logic [3:0]  exp_row[$];
    logic [3:0]  exp_col[$];
    logic        exp_bits[$];
    int          exp_pushes;

    int push_cnt, rd_cnt, se_total, se_runs, done_cnt;
    int first_push_cyc, first_se_cyc, done_cyc;
    logic se_prev = 1'b0;

    always @(negedge clk) begin
        if (buf_rd_en) rd_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (se_id && !se_prev) se_runs++;
        se_prev = se_id;
        if (se_id) begin
            se_total++;
            if (se_total == 1) first_se_cyc = cyc;
            if (exp_bits.size() == 0) check_val("scan_bit_overrun", se_total, SL);
            else check_val("si_id", si_id, exp_bits.pop_front());
        end
        if (data_wr_en || tags_wr_en) begin
            push_cnt++;
            if (push_cnt == 1) first_push_cyc = cyc;
            check_val("data_wr_en", data_wr_en, 1);
            check_val("tags_wr_en", tags_wr_en, 1);
            check_val("push_while_full", {data_full, tags_full}, 2'b00);
            if (exp_data.size() == 0) begin
                check_val("push_overrun", push_cnt, exp_pushes);
            end else begin
                check_val("data_out", data_out, exp_data.pop_front());
                check_val("row_tag", row_tag, exp_row.pop_front());
                check_val("col_tag", col_tag, exp_col.pop_front());
            end
        end
    end

    task automatic build_model(input bit cen, input int unsigned nw, input logic [3:0] rmax,
                               input logic [3:0] cmax, input logic [15:0] cb, input logic [15:0] db);
        int unsigned ncol;
        int unsigned nrow;
        logic [63:0] w;
        ncol = int'(cmax) + 1;
        nrow = int'(rmax) + 1;
        exp_data.delete(); exp_row.delete(); exp_col.delete(); exp_bits.delete();
        if (cen) begin
            for (int unsigned k = 0; k < SL; k++) begin
                w = mem_word(cb + 16'(k / DW));
                exp_bits.push_back(w[k % DW]);
            end
        end
        for (int unsigned i = 0; i < nw; i++) begin
            exp_data.push_back(mem_word(db + 16'(i)));
            exp_col.push_back(4'(i % ncol));
            exp_row.push_back(4'((i / ncol) % nrow));
        end
        exp_pushes = int'(nw);
        push_cnt = 0; rd_cnt = 0; se_total = 0; se_runs = 0; done_cnt = 0;
        first_push_cyc = -1; first_se_cyc = -1; done_cyc = -1;
    endtask

    task automatic launch(input bit cen, input int unsigned nw, input logic [3:0] rmax,
                          input logic [3:0] cmax, input logic [15:0] cb, input logic [15:0] db,
                          output int t0);
        @(posedge clk); #1;
        cfg_en = cen; cfg_base = cb; data_base = db; num_words = 16'(nw);
        row_max = rmax; col_max = cmax; start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs are latched at start; disturb them to prove it
        cfg_en = 1'($urandom); cfg_base = 16'($urandom); data_base = 16'($urandom);
        num_words = 16'($urandom); row_max = 4'($urandom); col_max = 4'($urandom);
        @(negedge clk);
        check_val("busy_after_start", busy, 1);
    endtask

    // bp: 0 = never full, 1 = random full flags, 2 = data_full for 3 cycles mid-burst
    task automatic run_pass(input bit cen, input int unsigned nw, input logic [3:0] rmax,
                            input logic [3:0] cmax, input logic [15:0] cb, input logic [15:0] db,
                            input int bp, input bit poke);
        int t0;
        int tmo;
        int unsigned base;
        build_model(cen, nw, rmax, cmax, cb, db);
        launch(cen, nw, rmax, cmax, cb, db, t0);
        tmo = 0;
        while (done_cnt == 0 && tmo < 3000) begin
            @(posedge clk); #1;
            tmo++;
            case (bp)
                1: begin
                    data_full = ($urandom % 4 == 0);
                    tags_full = ($urandom % 4 == 0);
                end
                2: begin
                    data_full = (cyc - t0 >= 4) && (cyc - t0 <= 6);
                    tags_full = 1'b0;
                end
                default: begin
                    data_full = 1'b0;
                    tags_full = 1'b0;
                end
            endcase
            if (poke) begin
                start = (cyc - t0 == 3);
                cfg_en = 1'b1;
                num_words = 16'd1;
            end
        end
        start = 1'b0; data_full = 1'b0; tags_full = 1'b0;
        check_val("done_seen", done_cnt, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("idle_after_done", busy, 0);
        check_val("done_pulses", done_cnt, 1);
        check_val("push_count", push_cnt, nw);
        check_val("pushes_missing", exp_data.size(), 0);
        check_val("scan_bits", se_total, cen ? SL : 0);
        check_val("scan_runs", se_runs, cen ? 1 : 0);
        check_val("read_count", rd_cnt, nw + (cen ? SW : 0));
        if (bp == 0) begin
            base = cen ? 721 : 0;
            check_val("done_latency", done_cyc - t0, (nw != 0) ? base + 2 + nw : base + 1);
            if (nw != 0) check_val("first_push_latency", first_push_cyc - t0, base + 2);
            if (cen) check_val("first_scan_latency", first_se_cyc - t0, 2);
        end
    endtask

    task automatic reset_mid_stream();
        int t0;
        int tmo;
        build_model(0, 10, 4'd2, 4'd3, 16'h0000, 16'h0700);
        launch(0, 10, 4'd2, 4'd3, 16'h0000, 16'h0700, t0);
        tmo = 0;
        while (push_cnt < 3 && tmo < 100) begin
            @(posedge clk); #1;
            tmo++;
        end
        check_val("pushes_before_reset", push_cnt, 3);
        exp_data.delete(); exp_row.delete(); exp_col.delete();
        exp_pushes = push_cnt;
        reset = 1'b1;
        @(negedge clk);
        check_val("reset_ctrl_outputs",
                  {busy, done, buf_rd_en, buf_rd_addr, se_id, si_id, data_wr_en, row_tag, col_tag, tags_wr_en},
                  '0);
        check_val("reset_data_out", data_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("no_done_after_reset", done_cnt, 0);
        check_val("no_push_after_reset", push_cnt, 3);
        check_val("idle_after_reset", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_en = 1'b0; cfg_base = '0; data_base = '0;
        num_words = '0; row_max = '0; col_max = '0; data_full = 1'b0; tags_full = 1'b0;
        exp_pushes = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ctrl_outputs",
                  {busy, done, buf_rd_en, buf_rd_addr, se_id, si_id, data_wr_en, row_tag, col_tag, tags_wr_en},
                  '0);
        check_val("rst_data_out", data_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_pass(0, 5, 4'd1, 4'd1, 16'h0100, 16'h0200, 0, 0);
        run_pass(1, 4, 4'd2, 4'd3, 16'h0040, 16'h0300, 0, 0);
        run_pass(0, 8, 4'd3, 4'd2, 16'h0000, 16'h0500, 2, 0);
        run_pass(0, 0, 4'd1, 4'd1, 16'h0000, 16'h0600, 0, 0);
        run_pass(1, 0, 4'd0, 4'd0, 16'hfffa, 16'h0000, 0, 0);
        reset_mid_stream();
        run_pass(0, 7, 4'd1, 4'd2, 16'h0000, 16'h0800, 0, 0);
        run_pass(0, 6, 4'd3, 4'd1, 16'h0000, 16'h0900, 0, 1);
        run_pass(0, 6, 4'd0, 4'd2, 16'h0000, 16'hfffd, 1, 0);
        for (int i = 0; i < 10; i++) begin
            run_pass(($urandom % 4) == 0, $urandom_range(0, 24), 4'($urandom), 4'($urandom),
                     16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
